// File: rtl/elastic_pipe_pkg.sv
// Shared types and the per-stage datapath operation for the elastic pipeline.
package elastic_pipe_pkg;

    localparam int unsigned OP_WIDTH       = 2;
    localparam int unsigned MAX_DATA_WIDTH = 64;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_ADD  = 2'd0,
        OP_SHL  = 2'd1,
        OP_XOR  = 2'd2,
        OP_PASS = 2'd3
    } pipe_op_e;

    // Evaluated at the widest supported width; callers truncate to their own width,
    // which also makes any shift of DATA_WIDTH or more collapse to zero.
    function automatic logic [MAX_DATA_WIDTH-1:0] stage_op(
        input pipe_op_e                  op,
        input logic [MAX_DATA_WIDTH-1:0] d,
        input logic [MAX_DATA_WIDTH-1:0] imm
    );
        logic [MAX_DATA_WIDTH-1:0] r;
        r = d;
        case (op)
            OP_ADD:  r = d + imm;
            OP_SHL:  r = d << imm;
            OP_XOR:  r = d ^ imm;
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/elastic_pipe_stage.sv
// One elastic register slice: holds valid/data and applies its configured op on capture.
module elastic_pipe_stage
    import elastic_pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IMM_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  prev_valid,
    input  logic [DATA_WIDTH-1:0] prev_data,
    input  logic                  next_ready,
    input  logic [OP_WIDTH-1:0]   op,
    input  logic [IMM_WIDTH-1:0]  imm,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data
);

    logic                  ready_c;
    logic [DATA_WIDTH-1:0] op_result_c;

    assign ready_c     = !valid || next_ready;
    assign op_result_c = DATA_WIDTH'(stage_op(pipe_op_e'(op),
                                              MAX_DATA_WIDTH'(prev_data),
                                              MAX_DATA_WIDTH'(imm)));

    // Data is only overwritten by a real capture; a drained slice keeps its stale data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (enable) begin
            if (flush) begin
                valid <= 1'b0;
            end else if (ready_c) begin
                valid <= prev_valid;
                if (prev_valid) begin
                    data <= op_result_c;
                end
            end
        end
    end

endmodule

// File: rtl/elastic_pipeline.sv
// N-stage back-pressurable op pipeline with flush, enable freeze and a saturating output counter.
module elastic_pipeline
    import elastic_pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_STAGES  = 4,
    parameter int unsigned IMM_WIDTH   = 8,
    parameter int unsigned COUNT_WIDTH = 8,
    parameter int unsigned DONE_COUNT  = 16
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            enable,
    input  logic                            flush,
    input  logic                            in_valid,
    input  logic [DATA_WIDTH-1:0]           in_data,
    output logic                            in_ready,
    output logic                            out_valid,
    output logic [DATA_WIDTH-1:0]           out_data,
    input  logic                            out_ready,
    input  logic [OP_WIDTH*NUM_STAGES-1:0]  cfg_op,
    input  logic [IMM_WIDTH*NUM_STAGES-1:0] cfg_imm,
    output logic [NUM_STAGES-1:0]           stage_valid,
    output logic                            busy,
    output logic [COUNT_WIDTH-1:0]          out_count,
    output logic                            done
);

    logic [NUM_STAGES-1:0] valid_q;
    logic [DATA_WIDTH-1:0] data_q [NUM_STAGES];
    logic [NUM_STAGES-1:0] next_ready_c;
    logic                  head_ready_c;
    logic                  out_hs_c;

    // Stage i may advance when the consumer is ready or any later stage holds a bubble;
    // derived straight from the valid registers so the ready chain has no combinational loop.
    always_comb begin : ready_scan
        logic room;
        room         = out_ready;
        next_ready_c = '0;
        for (int i = int'(NUM_STAGES) - 1; i >= 0; i--) begin
            next_ready_c[i] = room;
            room            = room || !valid_q[i];
        end
        head_ready_c = room;
    end

    for (genvar g = 0; g < int'(NUM_STAGES); g++) begin : g_stage
        logic                  prev_valid;
        logic [DATA_WIDTH-1:0] prev_data;

        if (g == 0) begin : g_head
            assign prev_valid = in_valid;
            assign prev_data  = in_data;
        end else begin : g_body
            assign prev_valid = valid_q[g-1];
            assign prev_data  = data_q[g-1];
        end

        elastic_pipe_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .IMM_WIDTH  (IMM_WIDTH)
        ) u_stage (
            .clk        (clk),
            .reset_n    (reset_n),
            .enable     (enable),
            .flush      (flush),
            .prev_valid (prev_valid),
            .prev_data  (prev_data),
            .next_ready (next_ready_c[g]),
            .op         (cfg_op[OP_WIDTH*g +: OP_WIDTH]),
            .imm        (cfg_imm[IMM_WIDTH*g +: IMM_WIDTH]),
            .valid      (valid_q[g]),
            .data       (data_q[g])
        );
    end

    assign in_ready    = enable && !flush && head_ready_c;
    assign out_valid   = enable && valid_q[NUM_STAGES-1];
    assign out_data    = data_q[NUM_STAGES-1];
    assign stage_valid = valid_q;
    assign busy        = |valid_q;
    assign out_hs_c    = out_valid && out_ready;

    // done lags the counter by one cycle and is only cleared by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_count <= '0;
            done      <= 1'b0;
        end else if (enable) begin
            if (out_hs_c && (out_count != '1)) begin
                out_count <= out_count + COUNT_WIDTH'(1);
            end
            if (out_count >= COUNT_WIDTH'(DONE_COUNT)) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_elastic_pipeline.sv
// Directed and randomized checks of elastic_pipeline against a queue-based reference model.
module tb_elastic_pipeline;

    localparam int unsigned DW = 32;
    localparam int unsigned NS = 4;
    localparam int unsigned IW = 8;
    localparam int unsigned CW = 8;
    localparam int unsigned DC = 16;

    logic            clk;
    logic            reset_n;
    logic            enable;
    logic            flush;
    logic            in_valid;
    logic [DW-1:0]   in_data;
    logic            in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_ready;
    logic [2*NS-1:0] cfg_op;
    logic [IW*NS-1:0] cfg_imm;
    logic [NS-1:0]   stage_valid;
    logic            busy;
    logic [CW-1:0]   out_count;
    logic            done;

    elastic_pipeline #(
        .DATA_WIDTH  (DW),
        .NUM_STAGES  (NS),
        .IMM_WIDTH   (IW),
        .COUNT_WIDTH (CW),
        .DONE_COUNT  (DC)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .cfg_op      (cfg_op),
        .cfg_imm     (cfg_imm),
        .stage_valid (stage_valid),
        .busy        (busy),
        .out_count   (out_count),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          failures;
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];
    int unsigned cnt_m;
    bit          done_m;
    bit          hold_v;
    logic [31:0] hold_d;
    bit          last_in_hs;
    logic [15:0] lfsr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Reference: apply each stage's op to a word in order, using plain 32-bit arithmetic.
    function automatic logic [31:0] model(input logic [31:0] d_in);
        logic [31:0] d;
        logic [1:0]  op;
        logic [7:0]  imm;
        d = d_in;
        for (int s = 0; s < int'(NS); s++) begin
            op  = cfg_op[2*s +: 2];
            imm = cfg_imm[IW*s +: IW];
            case (op)
                2'd0:    d = d + {24'd0, imm};
                2'd1:    d = (imm >= 8'd32) ? 32'd0 : (d << imm);
                2'd2:    d = d ^ {24'd0, imm};
                default: d = d;
            endcase
        end
        return d;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        cnt_m  = 0;
        done_m = 1'b0;
        hold_v = 1'b0;
    endtask

    // Observe one cycle just before its clock edge and advance the reference model.
    task automatic score();
        bit in_hs;
        bit out_hs;
        in_hs  = in_valid && in_ready;
        out_hs = out_valid && out_ready;
        check("occupancy", 32'($countones(stage_valid)), 32'(exp_q.size()));
        check("busy", 32'(busy), 32'(exp_q.size() != 0));
        check("out_count", 32'(out_count), cnt_m);
        check("done", 32'(done), 32'(done_m));
        if (enable && out_ready && !flush) check("in_ready_open", 32'(in_ready), 32'd1);
        if (!enable) begin
            check("frozen_in_ready", 32'(in_ready), 32'd0);
            check("frozen_out_valid", 32'(out_valid), 32'd0);
        end
        if (hold_v && out_valid) check("out_stable", out_data, hold_d);
        if (out_hs) begin
            got_q.push_back(out_data);
            if (exp_q.size() > 0) check("out_data", out_data, exp_q.pop_front());
            else check("out_nonempty", 32'(exp_q.size()), 32'd1);
        end
        if (enable) begin
            if (flush) exp_q.delete();
            if (cnt_m >= DC) done_m = 1'b1;
            if (out_hs && cnt_m < 255) cnt_m++;
        end
        if (in_hs) exp_q.push_back(model(in_data));
        hold_v     = out_valid && !out_ready;
        hold_d     = out_data;
        last_in_hs = in_hs;
    endtask

    task automatic step();
        @(negedge clk);
        score();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget, input bit use_lfsr);
        int c;
        c        = 0;
        in_valid = 1'b0;
        while (exp_q.size() > 0 && c < budget) begin
            if (use_lfsr) begin
                out_ready = lfsr[0];
                lfsr      = lfsr_next(lfsr);
            end
            step();
            c++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          idx;
        int          c;
        int          acc;
        int unsigned c0;
        logic [31:0] saved;

        checks     = 0;
        failures   = 0;
        lfsr       = 16'hACE1;
        last_in_hs = 1'b0;
        hold_d     = '0;
        model_reset();
        reset_n   = 1'b0;
        enable    = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        cfg_op    = 8'b00_10_01_00;
        cfg_imm   = {8'h55, 8'hAA, 8'h01, 8'h01};

        // Reset state
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_stage_valid", 32'(stage_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Single word, latency and result
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h0000_000A;
        step();
        check("single_accept", 32'(last_in_hs), 32'd1);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check("latency", 32'(lat + 1), 32'(NS));
        check("single_out_data", out_data, 32'h0000_0111);
        step();
        check("single_count", 32'(out_count), 32'd1);

        // Wraparound and zero operands
        got_q.delete();
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        step();
        in_data  = 32'h0000_0000;
        step();
        drain(50, 1'b0);
        check("pair_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() >= 2) begin
            check("wrap_result", got_q[0], 32'h0000_00FF);
            check("zero_result", got_q[1], 32'h0000_00FD);
        end

        // Stream 0..15 with LFSR back-pressure, then done timing
        apply_reset();
        got_q.delete();
        idx = 0;
        c   = 0;
        while (idx < 16 && c < 500) begin
            in_valid  = 1'b1;
            in_data   = 32'(idx);
            out_ready = lfsr[0];
            lfsr      = lfsr_next(lfsr);
            step();
            if (last_in_hs) idx++;
            c++;
        end
        check("stream_accepted", 32'(idx), 32'd16);
        drain(300, 1'b1);
        check("done_not_yet", 32'(done), 32'd0);
        out_ready = 1'b1;
        step();
        check("done_set", 32'(done), 32'd1);
        check("stream_count", 32'(out_count), 32'd16);
        check("stream_outputs", 32'(got_q.size()), 32'd16);
        for (int i = 0; i < got_q.size() && i < 16; i++) begin
            check("stream_order", got_q[i], model(32'(i)));
        end

        // Back-pressure: fill, hold stable, drain
        out_ready = 1'b0;
        got_q.delete();
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            step();
            if (last_in_hs) acc++;
        end
        in_valid = 1'b0;
        check("bp_accepted", 32'(acc), 32'd4);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_full", 32'(stage_valid), 32'hF);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        saved = exp_q.size() > 0 ? exp_q[0] : 32'd0;
        repeat (3) step();
        check("bp_head_data", out_data, saved);
        out_ready = 1'b1;
        drain(20, 1'b0);
        check("bp_drained", 32'(got_q.size()), 32'd4);

        // Flush on a full pipe without and with a coincident output handshake
        for (int pass = 0; pass < 2; pass++) begin
            out_ready = 1'b0;
            for (int k = 0; k < 4; k++) begin
                in_valid = 1'b1;
                in_data  = $urandom;
                step();
            end
            check("flush_full", 32'(stage_valid), 32'hF);
            c0        = cnt_m;
            out_ready = (pass == 1);
            flush     = 1'b1;
            in_data   = $urandom;
            step();
            check("flush_no_accept", 32'(last_in_hs), 32'd0);
            flush     = 1'b0;
            in_valid  = 1'b0;
            out_ready = 1'b0;
            check("flush_stage_valid", 32'(stage_valid), 32'd0);
            check("flush_busy", 32'(busy), 32'd0);
            check("flush_out_valid", 32'(out_valid), 32'd0);
            check("flush_count", 32'(out_count), c0 + 32'(pass));
            check("flush_done_kept", 32'(done), 32'd1);
        end

        // Enable freeze mid-stream
        got_q.delete();
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            step();
        end
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_data = $urandom;
            step();
            check("freeze_stage_valid", 32'(stage_valid), 32'h3);
            check("freeze_out_valid", 32'(out_valid), 32'd0);
        end
        enable = 1'b1;
        drain(20, 1'b0);
        check("freeze_resume", 32'(got_q.size()), 32'd2);

        // Asynchronous reset mid-stream
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            step();
        end
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data", out_data, 32'd0);
        check("arst_stage_valid", 32'(stage_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_out_count", 32'(out_count), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        got_q.delete();
        in_valid = 1'b1;
        in_data  = 32'h1234_5678;
        step();
        drain(20, 1'b0);
        check("post_rst_outputs", 32'(got_q.size()), 32'd1);
        if (got_q.size() >= 1) check("post_rst_result", got_q[0], model(32'h1234_5678));

        // Randomized traffic with random configuration, flushes and freezes
        for (int round = 0; round < 4; round++) begin
            cfg_op  = 8'($urandom);
            cfg_imm = $urandom;
            for (int k = 0; k < 200; k++) begin
                in_valid  = 1'($urandom_range(0, 1));
                in_data   = $urandom;
                out_ready = ($urandom_range(0, 3) != 0);
                flush     = ($urandom_range(0, 31) == 0);
                enable    = ($urandom_range(0, 15) != 0);
                step();
            end
            flush     = 1'b0;
            enable    = 1'b1;
            out_ready = 1'b1;
            drain(50, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
